// File: rtl/vector_cmd_seq.sv
// Vector command sequencer: FIFO-buffered MOVE/DRAW stream to line-drawer requests.
// Optional CLIP_COORD_EN saturates stored coordinates to X_MAX/Y_MAX.
module vector_cmd_seq #(
    parameter int FIFO_AW = 4,
    parameter int X_MAX   = 639,
    parameter int Y_MAX   = 479,
    parameter int ACK_TO  = 15
) (
    input  logic        clk50,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [15:0] cmd_data,
    output logic        cmd_ready,
    output logic [9:0]  x_from,
    output logic [9:0]  y_from,
    output logic [9:0]  x_to,
    output logic [9:0]  y_to,
    output logic        draw_enable,
    input  logic        draw_busy,
    output logic        idle,
    output logic        ack_err,
    output logic [15:0] lines_cnt
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = $clog2(ACK_TO + 1);
    localparam logic [FIFO_AW:0] L_FULL    = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] L_CONE    = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] L_PONE  = FIFO_AW'(1);
    localparam logic [TW-1:0] L_TO_LAST    = TW'(ACK_TO - 1);
    localparam logic [TW-1:0] L_TONE       = TW'(1);
    localparam logic [9:0] L_XMAX = 10'(X_MAX);
    localparam logic [9:0] L_YMAX = 10'(Y_MAX);
`ifdef CLIP_COORD_EN
    localparam bit L_CLIP = 1'b1;
`else
    localparam bit L_CLIP = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_ISSUE, S_ACK, S_WAIT
    } state_t;

    logic [11:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wp;
    logic [FIFO_AW-1:0] r_rp;
    logic [FIFO_AW:0]   r_cnt;
    state_t             r_st;
    logic [11:0]        r_cmd;
    logic [9:0]         r_x_pend;
    logic [9:0]         r_pen_x;
    logic [9:0]         r_pen_y;
    logic [TW-1:0]      r_to;

    logic       w_push;
    logic       w_pop;
    logic [1:0] w_op;
    logic [9:0] w_cx;
    logic [9:0] w_cy;
    logic       w_unused;

    function automatic logic [9:0] f_sat(input logic [9:0] c, input logic [9:0] m);
        return (L_CLIP && (c > m)) ? m : c;
    endfunction

    assign cmd_ready = (r_cnt != L_FULL);
    assign w_push    = cmd_valid & cmd_ready;
    assign w_pop     = (r_st == S_IDLE) && (r_cnt != '0);
    assign idle      = (r_st == S_IDLE) && (r_cnt == '0);
    assign w_op      = r_cmd[11:10];
    assign w_cx      = f_sat(r_cmd[9:0], L_XMAX);
    assign w_cy      = f_sat(r_cmd[9:0], L_YMAX);
    assign w_unused  = ^cmd_data[13:10];

    // Storage array carries no reset; only pointers and count are cleared.
    always_ff @(posedge clk50) begin
        if (w_push) r_mem[r_wp] <= {cmd_data[15:14], cmd_data[9:0]};
    end

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + L_PONE;
            if (w_pop)  r_rp <= r_rp + L_PONE;
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + L_CONE;
                2'b01:   r_cnt <= r_cnt - L_CONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            r_st        <= S_IDLE;
            r_cmd       <= '0;
            r_x_pend    <= '0;
            r_pen_x     <= '0;
            r_pen_y     <= '0;
            r_to        <= '0;
            x_from      <= '0;
            y_from      <= '0;
            x_to        <= '0;
            y_to        <= '0;
            draw_enable <= 1'b0;
            ack_err     <= 1'b0;
            lines_cnt   <= '0;
        end else begin
            draw_enable <= 1'b0;
            unique case (r_st)
                S_IDLE: begin
                    if (w_pop) begin
                        r_cmd <= r_mem[r_rp];
                        r_st  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_st <= S_IDLE;
                    unique case (w_op)
                        2'b00: r_x_pend <= w_cx;
                        2'b01: begin
                            r_pen_x <= r_x_pend;
                            r_pen_y <= w_cy;
                        end
                        2'b10: begin
                            x_from      <= r_pen_x;
                            y_from      <= r_pen_y;
                            x_to        <= r_x_pend;
                            y_to        <= w_cy;
                            r_pen_x     <= r_x_pend;
                            r_pen_y     <= w_cy;
                            draw_enable <= 1'b1;
                            lines_cnt   <= lines_cnt + 16'd1;
                            r_st        <= S_ISSUE;
                        end
                        default: begin
                            x_from      <= r_pen_x;
                            y_from      <= r_pen_y;
                            x_to        <= r_pen_x;
                            y_to        <= r_pen_y;
                            draw_enable <= 1'b1;
                            lines_cnt   <= lines_cnt + 16'd1;
                            r_st        <= S_ISSUE;
                        end
                    endcase
                end
                S_ISSUE: begin
                    r_to <= '0;
                    r_st <= S_ACK;
                end
                // Busy low on the first ACK cycle is expected drawer latency.
                S_ACK: begin
                    if (draw_busy) begin
                        r_st <= S_WAIT;
                    end else if (r_to == L_TO_LAST) begin
                        ack_err <= 1'b1;
                        r_st    <= S_IDLE;
                    end else begin
                        r_to <= r_to + L_TONE;
                    end
                end
                S_WAIT: begin
                    if (!draw_busy) r_st <= S_IDLE;
                end
                default: r_st <= S_IDLE;
            endcase
        end
    end
endmodule
